// File: rtl/perceptron_pkg.sv
// Shared types and widths for the perceptron training-sample feeder.
package perceptron_pkg;

    // Feeder sequencing: load samples, then serve one sample per neuron request.
    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_IDLE    = 3'd1,
        S_FETCH   = 3'd2,
        S_PRESENT = 3'd3,
        S_WAITLOW = 3'd4
    } state_t;

    localparam int X_W      = 7;   // two's complement input feature width
    localparam int T_W      = 2;   // target width
    localparam int N_W      = 32;  // width of the sample-count output
    localparam int SAMPLE_W = 2 * X_W + T_W;

    // One training sample as stored in the buffer (16 bits).
    typedef struct packed {
        logic [X_W-1:0] x1;
        logic [X_W-1:0] x2;
        logic [T_W-1:0] t;
    } sample_t;

endpackage

// File: rtl/sample_ram.sv
// DEPTH x 16 sample buffer: one write port, one registered read port.
module sample_ram
    import perceptron_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  sample_t           wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output sample_t           rdata
);

    sample_t mem [DEPTH];

    // Contents are intentionally not reset; they are undefined until loaded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read: data appears the cycle after re is asserted.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/perceptron_sample_feeder.sv
// Responder side of the neuron requestFlag/dataReady handshake.
//
// Handshake: the neuron raises requestFlag (a level) while the feeder is idle.
// Two cycles later the feeder drives dataReady high for exactly one cycle and
// the sample outputs are valid in that cycle. The feeder then waits for
// requestFlag to fall before accepting another request, so a held request
// yields only one sample. done returns the feeder to loading and suppresses
// any strobe in the cycle it is seen.
module perceptron_sample_feeder
    import perceptron_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int EPOCH_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrEn,
    input  logic [X_W-1:0]     wrX1,
    input  logic [X_W-1:0]     wrX2,
    input  logic [T_W-1:0]     wrT,
    input  logic               clear,
    input  logic               start,
    input  logic               requestFlag,
    input  logic               done,
    output logic               dataReady,
    output logic [N_W-1:0]     nOutput,
    output logic [X_W-1:0]     x1Output,
    output logic [X_W-1:0]     x2Output,
    output logic [T_W-1:0]     tOutput,
    output logic               full,
    output logic               serving,
    output logic [EPOCH_W-1:0] epochCount,
    output state_t             debugState
);

    // count needs one extra bit because it can reach DEPTH itself.
    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W:0]     count;
    logic [ADDR_W:0]     count_load;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                wr_ok;
    logic                arm;
    logic                ram_re;
    logic                last_sample;
    sample_t             wr_sample;
    sample_t             ram_q;
    sample_t             out_q;
    logic [ADDR_W:0]     nout_q;

    assign wr_sample = '{x1: wrX1, x2: wrX2, t: wrT};

    sample_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (count[ADDR_W-1:0]),
        .wdata (wr_sample),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // Next state, host-write qualification and the dataReady strobe.
    always_comb begin
        state_nxt   = state;
        wr_ok       = 1'b0;
        count_load  = count;
        arm         = 1'b0;
        ram_re      = 1'b0;
        dataReady   = 1'b0;
        last_sample = ({1'b0, rd_ptr} == (count - 1'b1));
        case (state)
            S_LOAD: begin
                // clear beats a same-cycle write; start sees the post-write count.
                wr_ok = wrEn && !clear && (count < CNT_DEPTH);
                if (clear) begin
                    count_load = '0;
                end else if (wr_ok) begin
                    count_load = count + 1'b1;
                end
                arm = start && (count_load != '0);
                if (arm) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                // Read is launched as the request is accepted so the sample
                // is sitting at the RAM output during S_FETCH.
                if (done) begin
                    state_nxt = S_LOAD;
                end else if (requestFlag) begin
                    state_nxt = S_FETCH;
                    ram_re    = 1'b1;
                end
            end
            S_FETCH: begin
                state_nxt = done ? S_LOAD : S_PRESENT;
            end
            S_PRESENT: begin
                dataReady = !done;
                state_nxt = done ? S_LOAD : S_WAITLOW;
            end
            S_WAITLOW: begin
                if (done) begin
                    state_nxt = S_LOAD;
                end else if (!requestFlag) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Sample count: only changes while loading; kept across done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (state == S_LOAD) begin
            count <= count_load;
        end
    end

    // Read pointer and epoch counter: wrap after the last stored sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            epochCount <= '0;
        end else if (state == S_LOAD) begin
            if (arm) begin
                rd_ptr     <= '0;
                epochCount <= '0;
            end
        end else if (done) begin
            rd_ptr <= '0;
        end else if (state == S_PRESENT) begin
            if (last_sample) begin
                rd_ptr <= '0;
                if (epochCount != '1) begin
                    epochCount <= epochCount + 1'b1;
                end
            end else begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Output registers load on entry to S_PRESENT and hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            nout_q <= '0;
        end else if ((state == S_FETCH) && !done) begin
            out_q  <= ram_q;
            nout_q <= count;
        end
    end

    assign x1Output   = out_q.x1;
    assign x2Output   = out_q.x2;
    assign tOutput    = out_q.t;
    assign nOutput    = {{(N_W - ADDR_W - 1){1'b0}}, nout_q};
    assign full       = (count == CNT_DEPTH);
    assign serving    = (state != S_LOAD);
    assign debugState = state;

endmodule

// File: tb/tb_perceptron_sample_feeder.sv
// Randomized scoreboard bench for perceptron_sample_feeder.
module tb_perceptron_sample_feeder;
    import perceptron_pkg::*;

    localparam int DEPTH   = 64;
    localparam int ADDR_W  = 6;
    localparam int EPOCH_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               wrEn = 1'b0;
    logic [6:0]         wrX1 = '0;
    logic [6:0]         wrX2 = '0;
    logic [1:0]         wrT = '0;
    logic               clear = 1'b0;
    logic               start = 1'b0;
    logic               requestFlag = 1'b0;
    logic               done = 1'b0;
    logic               dataReady;
    logic [31:0]        nOutput;
    logic [6:0]         x1Output;
    logic [6:0]         x2Output;
    logic [1:0]         tOutput;
    logic               full;
    logic               serving;
    logic [EPOCH_W-1:0] epochCount;
    state_t             dbg_state;

    perceptron_sample_feeder #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .EPOCH_W (EPOCH_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wrEn        (wrEn),
        .wrX1        (wrX1),
        .wrX2        (wrX2),
        .wrT         (wrT),
        .clear       (clear),
        .start       (start),
        .requestFlag (requestFlag),
        .done        (done),
        .dataReady   (dataReady),
        .nOutput     (nOutput),
        .x1Output    (x1Output),
        .x2Output    (x2Output),
        .tOutput     (tOutput),
        .full        (full),
        .serving     (serving),
        .epochCount  (epochCount),
        .debugState  (dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    // Scoreboard: {x1, x2, t, n} expected per strobe.
    logic [47:0] exp_q[$];
    logic [47:0] mon_exp;

    // Reference model: a queue of stored samples plus a modular read index.
    logic [15:0] model_buf[$];
    int          model_ptr;
    int          model_epoch;
    bit          model_serving;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe pops one expectation.
    always @(negedge clk) begin
        if (dataReady === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL strobe: unexpected dataReady with empty scoreboard");
            end else begin
                mon_exp = exp_q.pop_front();
                check("sample", 64'({x1Output, x2Output, tOutput, nOutput}), 64'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model_buf.delete();
        model_ptr     = 0;
        model_epoch   = 0;
        model_serving = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wrEn = 0; clear = 0; start = 0; requestFlag = 0; done = 0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic write_sample(input logic [6:0] x1, input logic [6:0] x2,
                                input logic [1:0] t, input bit clr);
        wrX1 = x1; wrX2 = x2; wrT = t; wrEn = 1'b1; clear = clr;
        tick();
        wrEn = 1'b0; clear = 1'b0;
        if (!model_serving) begin
            if (clr) model_buf.delete();
            else if (model_buf.size() < DEPTH) model_buf.push_back({x1, x2, t});
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (!model_serving && model_buf.size() > 0) begin
            model_serving = 1;
            model_ptr     = 0;
            model_epoch   = 0;
        end
    endtask

    task automatic do_done();
        done = 1'b1;
        tick();
        done = 1'b0;
        if (model_serving) begin
            model_serving = 0;
            model_ptr     = 0;
        end
    endtask

    // Issue one request held for `hold` cycles; check latency and pulse count.
    task automatic request(input int hold);
        int lat;
        int p0;
        lat = -1;
        p0  = pulse_cnt;
        if (model_serving) begin
            exp_q.push_back({model_buf[model_ptr], 32'(model_buf.size())});
            model_ptr++;
            if (model_ptr == model_buf.size()) begin
                model_ptr = 0;
                if (model_epoch < 65535) model_epoch++;
            end
        end
        requestFlag = 1'b1;
        for (int c = 1; c <= hold + 8; c++) begin
            tick();
            if (c >= hold) requestFlag = 1'b0;
            if (dataReady && lat < 0) lat = c;
        end
        check("latency", 64'(lat), 64'd2);
        check("pulses", 64'(pulse_cnt - p0), 64'd1);
    endtask

    initial begin
        int p0;
        int n;
        // Reset state
        do_reset();
        check("rst_dataReady", 64'(dataReady), 64'd0);
        check("rst_nOutput",   64'(nOutput),   64'd0);
        check("rst_x",         64'({x1Output, x2Output, tOutput}), 64'd0);
        check("rst_full",      64'(full),      64'd0);
        check("rst_serving",   64'(serving),   64'd0);
        check("rst_epoch",     64'(epochCount), 64'd0);

        // Directed: three samples, four single-cycle requests
        write_sample(7'd5,    7'h7D, 2'd1, 0);
        write_sample(7'h7E,   7'd7,  2'd0, 0);
        write_sample(7'd1,    7'd1,  2'd1, 0);
        do_start();
        check("serving_after_start", 64'(serving), 64'd1);
        for (int i = 0; i < 4; i++) begin
            request(1);
            if (i == 2) check("epoch_after_3", 64'(epochCount), 64'd1);
        end
        check("epoch_after_4", 64'(epochCount), 64'(model_epoch));

        // Held request: one pulse only, then the next sample on a fresh request
        request(10);
        request(1);

        // done together with a request from S_IDLE
        p0 = pulse_cnt;
        requestFlag = 1'b1;
        do_done();
        requestFlag = 1'b0;
        check("done_serving", 64'(serving), 64'd0);
        tick(); tick(); tick();
        check("done_no_strobe", 64'(pulse_cnt - p0), 64'd0);
        check("done_count_kept", 64'(full), 64'd0);
        do_start();
        check("restart_epoch", 64'(epochCount), 64'd0);
        request(1);
        request(1);

        // clear together with wrEn, then start with an empty buffer
        do_done();
        write_sample(7'd9, 7'd9, 2'd2, 1);
        do_start();
        check("start_empty_serving", 64'(serving), 64'd0);

        // Randomized rounds
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++)
                write_sample(7'($urandom), 7'($urandom), 2'($urandom), 0);
            do_start();
            for (int k = $urandom_range(3, 15); k > 0; k--) begin
                request($urandom_range(1, 4));
                repeat ($urandom_range(0, 2)) tick();
            end
            check("rand_epoch", 64'(epochCount), 64'(model_epoch));
            do_done();
            write_sample(7'd0, 7'd0, 2'd0, 1);
        end

        // Full buffer: 65 writes, 65th ignored
        do_reset();
        for (int i = 0; i < 63; i++)
            write_sample(7'($urandom), 7'($urandom), 2'($urandom), 0);
        check("full_at_63", 64'(full), 64'd0);
        write_sample(7'($urandom), 7'($urandom), 2'($urandom), 0);
        check("full_at_64", 64'(full), 64'd1);
        write_sample(7'h55, 7'h2A, 2'd3, 0);
        check("full_at_65", 64'(full), 64'd1);
        do_start();
        request(1);
        request(2);

        // Reset while presenting a sample (no expectation pushed)
        requestFlag = 1'b1;
        tick();
        tick();
        check("present_strobe", 64'(dataReady), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_dataReady", 64'(dataReady), 64'd0);
        check("rst_mid_outputs", 64'({x1Output, x2Output, tOutput, nOutput}), 64'd0);
        check("rst_mid_serving", 64'(serving), 64'd0);
        check("rst_mid_full", 64'(full), 64'd0);
        requestFlag = 1'b0;
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        do_start();
        check("start_after_rst", 64'(serving), 64'd0);
        tick(); tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/perceptron_sample_feeder.md
Name: perceptron_sample_feeder

Overview:
- Supplies training samples to the perceptron neuron. It is the responder side of the neuron's requestFlag/dataReady handshake.
- A host first loads samples (x1, x2, t) into an internal buffer. Once armed, the feeder answers each neuron request with the next sample plus the sample count n.
- Reads wrap to sample 0 at the end of the buffer, so the neuron can run multiple epochs. Serving stops when the neuron asserts done.

Parameters:
- DEPTH, 64, maximum number of stored samples.
- ADDR_W, 6, pointer width; must satisfy 2^ADDR_W >= DEPTH.
- EPOCH_W, 16, width of the epoch counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wrEn  input  1  host write strobe; accepted only in S_LOAD.
- wrX1  input  7  sample x1 (two's complement).
- wrX2  input  7  sample x2 (two's complement).
- wrT  input  2  sample target t.
- clear  input  1  in S_LOAD, empties the buffer (count := 0).
- start  input  1  arms serving when count > 0.
- requestFlag  input  1  neuron request, level signal.
- done  input  1  neuron training finished.
- dataReady  output  1  one-cycle strobe: sample outputs are valid.
- nOutput  output  32  zero-extended sample count.
- x1Output  output  7  served x1.
- x2Output  output  7  served x2.
- tOutput  output  2  served t.
- full  output  1  count == DEPTH.
- serving  output  1  FSM is not in S_LOAD.
- epochCount  output  EPOCH_W  number of completed read-pointer wraps.

Behaviour:
- Reset (async, immediate, from any state):
  - state = S_LOAD; count, rdPtr, epochCount = 0.
  - dataReady = 0; all data outputs = 0; full = 0; serving = 0.
  - Buffer contents are undefined after reset.
- S_LOAD:
  - wrEn with count < DEPTH writes buf[count] and increments count.
  - wrEn with count == DEPTH is ignored and count is unchanged.
  - clear sets count := 0. If clear and wrEn occur in the same cycle, clear wins and no write happens.
  - start with count > 0 goes to S_IDLE, rdPtr := 0, epochCount := 0.
  - start with count == 0 is ignored.
  - If start and wrEn occur in the same cycle, the write completes first and the new count is used.
- S_IDLE:
  - requestFlag == 1 goes to S_FETCH.
  - wrEn, clear and start are ignored in every state except S_LOAD.
- S_FETCH:
  - Buffer read at rdPtr (registered read, one cycle).
  - Goes to S_PRESENT.
- S_PRESENT:
  - Output registers load the sample; nOutput := count; dataReady = 1 for exactly this cycle.
  - Pointer update: rdPtr := rdPtr + 1. If rdPtr == count-1, rdPtr := 0 and epochCount increments, saturating at all-ones.
  - Goes to S_WAITLOW.
  - Latency: request seen in S_IDLE at cycle k gives dataReady at cycle k+2.
- S_WAITLOW:
  - requestFlag == 0 goes to S_IDLE.
  - A held-high requestFlag never produces a second sample.
- Data outputs hold their last value between strobes.
- done == 1 in any serving state returns to S_LOAD next cycle.
  - dataReady is forced to 0 in that cycle, even if the FSM is in S_PRESENT.
  - count and buffer contents are kept; rdPtr := 0.
  - done has priority over requestFlag.
- count == 1: every request returns sample 0, and epochCount increments on each serve.
- serving = (state != S_LOAD); full = (count == DEPTH); both are combinational from registers.
- nOutput is zero-extended from ADDR_W+1 bits. count can reach DEPTH, so it needs the extra bit.

Decomposition:
- Package perceptron_pkg:
  - State enum: S_LOAD, S_IDLE, S_FETCH, S_PRESENT, S_WAITLOW.
  - Constants X_W = 7, T_W = 2, N_W = 32.
  - Packed sample struct {x1, x2, t}, 16 bits.
- One sub-module: sample_ram, a DEPTH x 16 single-port-write, registered-read memory.
- FSM, pointers and output registers stay in the top module.

Test Plan:
- Load 3 samples {(5,-3,1), (-2,7,0), (1,1,1)}, start, then 4 single-cycle requests. Required:
  - Samples served in order 0, 1, 2, 0.
  - nOutput = 3 on every strobe.
  - dataReady 2 cycles after each request.
  - epochCount = 1 after the 3rd serve.
- Hold requestFlag high for 10 cycles -> exactly one dataReady pulse. Drop it, raise it again -> the next sample is served.
- Write 65 samples with DEPTH = 64 -> full = 1 after the 64th write; the 65th is ignored; nOutput = 64.
- start with count = 0 -> serving stays 0. clear and wrEn in the same cycle -> count = 0.
- Raise done in the same cycle as requestFlag from S_IDLE -> no dataReady; serving = 0 next cycle.
  - Then start again -> sample 0 is served first; count is still 3.
- Assert rst while in S_PRESENT -> dataReady drops immediately; all outputs read 0; start with no reload is ignored.
